cache_way_ctrl: RTL and testbench
=================================

Name: cache_way_ctrl

Overview:
- Sequencing controller for the 2-way set-associative cache.
- Accepts CPU read/write requests and sequences tag lookup against externally compared tag-match inputs.
- Owns the per-set valid and LRU bits and picks the victim way on a read miss.
- Runs the memory handshake for fills and write-throughs, and drives the one-hot way-select and write enables into the tag/data arrays.

Parameters:
- SETS, 8, number of sets (power of 2, ≥2).
- IDX_W, 3, set index width, equal to log2(SETS).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  CPU request present.
- req_ready  out  1  controller can accept a request this cycle.
- req_wr  in  1  1 = write, 0 = read; sampled at acceptance.
- req_index  in  IDX_W  set index; sampled at acceptance.
- hit0, hit1  in  1 each  external tag-compare result for way0/way1 at the registered index; valid in LOOKUP.
- flush  in  1  invalidate entire cache.
- idx_q  out  IDX_W  registered index driving the tag/data arrays.
- way_sel  out  2  one-hot way select (01 = way0, 10 = way1, 00 = none).
- tag_we  out  1  write tag of way_sel at idx_q.
- data_we  out  1  write data of way_sel at idx_q.
- mem_req  out  1  memory request; held until mem_ack.
- mem_wr  out  1  1 = write-through, 0 = line fill; stable while mem_req is high.
- mem_ack  in  1  memory completion; single-cycle pulse.
- resp_valid  out  1  one-cycle response pulse.
- resp_hit  out  1  1 = request hit; qualified by resp_valid.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All valid[]=0, all lru[]=0, idx_q=0. Outputs: req_ready=0 while rst_n is low, then 1 in IDLE. way_sel=00; tag_we, data_we, mem_req, mem_wr, resp_valid, resp_hit all 0. Reset mid-transaction abandons it; no response is issued.
- States: IDLE, LOOKUP, FILL, WTHRU, RESP.
- IDLE, req_ready=1 unless flush=1.
  - flush=1: clear every valid and lru bit in one cycle; no request is accepted that cycle. flush has priority over req_valid.
  - Otherwise req_valid=1: latch req_wr and req_index into idx_q, then go to LOOKUP.
- LOOKUP: hv0=hit0&valid[idx_q], hv1=hit1&valid[idx_q]. If both are set, way0 wins.
  - Read hit: way_sel=hit way, lru[idx_q]=~way, go to RESP with resp_hit=1.
  - Read miss: choose the victim, latch it, then go to FILL.
    - Victim is the first invalid way, way0 first.
    - If both ways are valid, victim is way1 when lru=1, else way0.
  - Write hit: data_we=1 and way_sel=hit way this cycle, lru updated, hit flag latched, go to WTHRU.
  - Write miss: no allocate and no array write; go to WTHRU.
- FILL: mem_req=1, mem_wr=0. On mem_ack, in the same cycle:
  - tag_we=1, data_we=1, way_sel=victim;
  - valid[idx_q]=1 for the victim, lru[idx_q]=~victim;
  - go to RESP with resp_hit=0.
- WTHRU: mem_req=1, mem_wr=1. On mem_ack, go to RESP with resp_hit equal to the latched hit flag.
- RESP: resp_valid=1 for exactly one cycle, then IDLE.
- Latency from acceptance cycle A:
  - Read hit: resp_valid at A+2.
  - Read miss or any write: resp_valid at ack cycle+1.
- mem_ack is ignored outside FILL/WTHRU. mem_ack in the first FILL/WTHRU cycle is legal.
- req_ready=0 in every non-IDLE state. flush outside IDLE is ignored.
- way_sel is 00 whenever tag_we=0 and data_we=0, except for the read-hit cycle in LOOKUP.
- LRU encoding: lru=1 means way1 is least recently used.

Test Plan:
- Reset, then read idx 3 with hit0=hit1=0 → FILL; mem_ack 2 cycles later → tag_we=data_we=1, way_sel=01; resp_valid with resp_hit=0; valid[3]=01, lru[3]=1.
- Repeat read idx 3 with hit0=1 → resp_valid at A+2 with resp_hit=1, way_sel=01 in LOOKUP, no mem_req; lru[3]=1.
- Fill way1 at idx 3, read-hit way0, then read miss at idx 3 → victim way1 (way_sel=10 on fill); next miss → victim way0.
- Write hit at idx 5 on way1 → data_we=1, way_sel=10 in LOOKUP; mem_req=1 with mem_wr=1 until ack; resp_hit=1. Write miss → no data_we/tag_we, resp_hit=0.
- flush=1 and req_valid=1 in the same IDLE cycle → request not accepted, all valid bits cleared. Next read with hit0=1 → miss (FILL).
- rst_n pulled low during FILL with mem_req=1 → mem_req=0 immediately, no resp_valid. Arrays invalid afterwards, so the next read with hit0=1 misses.

Source files
------------

// File: rtl/cache_way_ctrl.sv
// Sequencing controller for a 2-way set-associative cache: tag lookup, victim choice, fills and write-throughs.
// Read hit responds two cycles after acceptance; misses and writes respond the cycle after mem_ack; req_ready only in IDLE.
module cache_way_ctrl #(
  parameter int SETS  = 8,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_wr,
  input  logic [IDX_W-1:0] req_index,
  input  logic             hit0,
  input  logic             hit1,
  input  logic             flush,
  output logic [IDX_W-1:0] idx_q,
  output logic [1:0]       way_sel,
  output logic             tag_we,
  output logic             data_we,
  output logic             mem_req,
  output logic             mem_wr,
  input  logic             mem_ack,
  output logic             resp_valid,
  output logic             resp_hit
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    FILL   = 3'd2,
    WTHRU  = 3'd3,
    RESP   = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [SETS-1:0] valid0;
  logic [SETS-1:0] valid1;
  logic [SETS-1:0] lru;
  logic            wr_q;
  logic            hit_q;
  logic            victim_q;

  logic v0, v1, hv0, hv1, any_hit, hit_way, victim;

  function automatic logic [1:0] onehot(input logic way);
    return way ? 2'b10 : 2'b01;
  endfunction

  assign v0      = valid0[idx_q];
  assign v1      = valid1[idx_q];
  assign hv0     = hit0 & v0;
  assign hv1     = hit1 & v1;
  assign any_hit = hv0 | hv1;
  // way0 wins when both ways report a hit
  assign hit_way = ~hv0;
  // first invalid way, else the least recently used one
  assign victim  = !v0 ? 1'b0 : (!v1 ? 1'b1 : lru[idx_q]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (!flush && req_valid) begin
          state_nxt = LOOKUP;
        end
      end
      LOOKUP: begin
        if (wr_q) begin
          state_nxt = WTHRU;
        end else if (any_hit) begin
          state_nxt = RESP;
        end else begin
          state_nxt = FILL;
        end
      end
      FILL: begin
        if (mem_ack) begin
          state_nxt = RESP;
        end
      end
      WTHRU: begin
        if (mem_ack) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    req_ready  = 1'b0;
    way_sel    = 2'b00;
    tag_we     = 1'b0;
    data_we    = 1'b0;
    mem_req    = 1'b0;
    mem_wr     = 1'b0;
    resp_valid = 1'b0;
    resp_hit   = 1'b0;
    case (state)
      IDLE: begin
        req_ready = rst_n & ~flush;
      end
      LOOKUP: begin
        if (any_hit) begin
          way_sel = onehot(hit_way);
          data_we = wr_q;
        end
      end
      FILL: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          way_sel = onehot(victim_q);
          tag_we  = 1'b1;
          data_we = 1'b1;
        end
      end
      WTHRU: begin
        mem_req = 1'b1;
        mem_wr  = 1'b1;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_hit   = hit_q;
      end
      default: begin
        req_ready = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid0   <= '0;
      valid1   <= '0;
      lru      <= '0;
      idx_q    <= '0;
      wr_q     <= 1'b0;
      hit_q    <= 1'b0;
      victim_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (flush) begin
            valid0 <= '0;
            valid1 <= '0;
            lru    <= '0;
          end else if (req_valid) begin
            idx_q <= req_index;
            wr_q  <= req_wr;
          end
        end
        LOOKUP: begin
          hit_q <= any_hit;
          if (any_hit) begin
            lru[idx_q] <= ~hit_way;
          end else begin
            victim_q <= victim;
          end
        end
        FILL: begin
          if (mem_ack) begin
            if (victim_q) begin
              valid1[idx_q] <= 1'b1;
            end else begin
              valid0[idx_q] <= 1'b1;
            end
            lru[idx_q] <= ~victim_q;
          end
        end
        default: begin
          hit_q <= hit_q;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_way_ctrl.sv
// Directed bench for cache_way_ctrl; outputs packed as {req_ready, way_sel, tag_we, data_we, mem_req, mem_wr, resp_valid, resp_hit}.
module tb_cache_way_ctrl;

  localparam logic [8:0] O_NONE  = 9'h000;
  localparam logic [8:0] O_IDLE  = 9'h100;
  localparam logic [8:0] O_FILL  = 9'h008;
  localparam logic [8:0] O_WT    = 9'h00C;
  localparam logic [8:0] O_RESP0 = 9'h002;
  localparam logic [8:0] O_RESP1 = 9'h003;
  localparam logic [8:0] O_ACK0  = 9'h078;
  localparam logic [8:0] O_ACK1  = 9'h0B8;
  localparam logic [8:0] O_RH0   = 9'h040;
  localparam logic [8:0] O_RH1   = 9'h080;
  localparam logic [8:0] O_WH1   = 9'h090;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_wr = 1'b0;
  logic [2:0] req_index = 3'd0;
  logic       hit0 = 1'b0;
  logic       hit1 = 1'b0;
  logic       flush = 1'b0;
  logic [2:0] idx_q;
  logic [1:0] way_sel;
  logic       tag_we, data_we, mem_req, mem_wr;
  logic       mem_ack = 1'b0;
  logic       resp_valid, resp_hit;

  int vectors = 0;
  int miscompares = 0;

  cache_way_ctrl #(.SETS(8), .IDX_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr), .req_index(req_index),
    .hit0(hit0), .hit1(hit1), .flush(flush),
    .idx_q(idx_q), .way_sel(way_sel), .tag_we(tag_we), .data_we(data_we),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_ack(mem_ack),
    .resp_valid(resp_valid), .resp_hit(resp_hit)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] outs();
    return {req_ready, way_sel, tag_we, data_we, mem_req, mem_wr, resp_valid, resp_hit};
  endfunction

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full request from IDLE back to IDLE; exp_mem == 0 means no memory phase.
  task automatic txn(input string name, input logic wr, input logic [2:0] idx,
                     input logic h0, input logic h1, input logic [8:0] exp_lk,
                     input logic [8:0] exp_mem, input int ack_wait,
                     input logic [8:0] exp_ack, input logic [8:0] exp_resp);
    req_valid = 1'b1;
    req_wr    = wr;
    req_index = idx;
    @(negedge clk);
    chk({name, ":accept"}, outs(), O_IDLE);
    tick();
    req_valid = 1'b0;
    req_wr    = 1'b0;
    hit0      = h0;
    hit1      = h1;
    @(negedge clk);
    chk({name, ":lookup"}, outs(), exp_lk);
    chk({name, ":idx_q"}, idx_q, idx);
    tick();
    hit0 = 1'b0;
    hit1 = 1'b0;
    if (exp_mem != O_NONE) begin
      for (int i = 0; i < ack_wait; i++) begin
        @(negedge clk);
        chk({name, ":mem_wait"}, outs(), exp_mem);
        tick();
      end
      mem_ack = 1'b1;
      @(negedge clk);
      chk({name, ":mem_ack"}, outs(), exp_ack);
      tick();
      mem_ack = 1'b0;
    end
    @(negedge clk);
    chk({name, ":resp"}, outs(), exp_resp);
    tick();
    @(negedge clk);
    chk({name, ":idle"}, outs(), O_IDLE);
    tick();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset:outs", outs(), O_NONE);
    chk("reset:idx_q", idx_q, 3'd0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset:outs", outs(), O_IDLE);
    tick();

    // set 3: fill way0, hit way0, fill way1, then LRU-driven victims
    txn("rd3_miss_w0", 1'b0, 3'd3, 1'b0, 1'b0, O_NONE, O_FILL, 2, O_ACK0, O_RESP0);
    txn("rd3_hit_w0",  1'b0, 3'd3, 1'b1, 1'b0, O_RH0,  O_NONE, 0, O_NONE, O_RESP1);
    txn("rd3_miss_w1", 1'b0, 3'd3, 1'b0, 1'b0, O_NONE, O_FILL, 1, O_ACK1, O_RESP0);
    txn("rd3_hit_w0b", 1'b0, 3'd3, 1'b1, 1'b0, O_RH0,  O_NONE, 0, O_NONE, O_RESP1);
    txn("rd3_vict_w1", 1'b0, 3'd3, 1'b0, 1'b0, O_NONE, O_FILL, 0, O_ACK1, O_RESP0);
    txn("rd3_vict_w0", 1'b0, 3'd3, 1'b0, 1'b0, O_NONE, O_FILL, 1, O_ACK0, O_RESP0);
    txn("rd3_both",    1'b0, 3'd3, 1'b1, 1'b1, O_RH0,  O_NONE, 0, O_NONE, O_RESP1);
    txn("rd3_hit_w1",  1'b0, 3'd3, 1'b0, 1'b1, O_RH1,  O_NONE, 0, O_NONE, O_RESP1);
    txn("rd3_vict_w0b",1'b0, 3'd3, 1'b0, 1'b0, O_NONE, O_FILL, 0, O_ACK0, O_RESP0);

    // set 5: fill both ways, write hit on way1, write misses
    txn("rd5_miss_w0", 1'b0, 3'd5, 1'b0, 1'b0, O_NONE, O_FILL, 0, O_ACK0, O_RESP0);
    txn("rd5_miss_w1", 1'b0, 3'd5, 1'b0, 1'b0, O_NONE, O_FILL, 0, O_ACK1, O_RESP0);
    txn("wr5_hit_w1",  1'b1, 3'd5, 1'b0, 1'b1, O_WH1,  O_WT,   2, O_WT,   O_RESP1);
    txn("wr5_miss",    1'b1, 3'd5, 1'b0, 1'b0, O_NONE, O_WT,   0, O_WT,   O_RESP0);
    txn("wr6_invalid", 1'b1, 3'd6, 1'b0, 1'b1, O_NONE, O_WT,   1, O_WT,   O_RESP0);
    txn("rd5_vict_w0", 1'b0, 3'd5, 1'b0, 1'b0, O_NONE, O_FILL, 0, O_ACK0, O_RESP0);

    // stray mem_ack in IDLE has no effect
    mem_ack = 1'b1;
    @(negedge clk);
    chk("stray_ack", outs(), O_IDLE);
    tick();
    mem_ack = 1'b0;
    @(negedge clk);
    chk("stray_ack_after", outs(), O_IDLE);
    tick();

    // flush beats a simultaneous request and clears every valid bit
    flush     = 1'b1;
    req_valid = 1'b1;
    req_index = 3'd3;
    @(negedge clk);
    chk("flush:ready", outs(), O_NONE);
    tick();
    flush     = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    chk("flush:not_accepted", outs(), O_IDLE);
    tick();
    txn("post_flush_rd3", 1'b0, 3'd3, 1'b1, 1'b0, O_NONE, O_FILL, 0, O_ACK0, O_RESP0);
    txn("post_flush_rd5", 1'b0, 3'd5, 1'b0, 1'b1, O_NONE, O_FILL, 1, O_ACK0, O_RESP0);

    // reset during FILL abandons the request
    req_valid = 1'b1;
    req_index = 3'd2;
    tick();
    req_valid = 1'b0;
    @(negedge clk);
    chk("rst_fill:lookup", outs(), O_NONE);
    tick();
    @(negedge clk);
    chk("rst_fill:in_fill", outs(), O_FILL);
    tick();
    rst_n = 1'b0;
    #1;
    chk("rst_fill:immediate", outs(), O_NONE);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_fill:held", outs(), O_NONE);
    end
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_fill:idle", outs(), O_IDLE);
    tick();
    txn("post_rst_rd3", 1'b0, 3'd3, 1'b1, 1'b0, O_NONE, O_FILL, 0, O_ACK0, O_RESP0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
